// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   XLEN          default operand/result width
//   mdu_op_e      RISC-V M-extension operation codes (3 bits)
//   mdu_state_e   control FSM states
//   op_* helpers  classify an operation code
package mdu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'd0,
      MDU_MULH   = 3'd1,
      MDU_MULHSU = 3'd2,
      MDU_MULHU  = 3'd3,
      MDU_DIV    = 3'd4,
      MDU_DIVU   = 3'd5,
      MDU_REM    = 3'd6,
      MDU_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_CALC = 2'd1,
      MDU_DONE = 2'd2
   } mdu_state_e;

   // Divide-class operations all have bit 2 set.
   function automatic logic op_is_div(input mdu_op_e op);
      return op[2];
   endfunction

   // Operations that want the remainder rather than the quotient.
   function automatic logic op_is_rem(input mdu_op_e op);
      return op[2] & op[1];
   endfunction

   // rs1 is treated as two's complement.
   function automatic logic op_a_signed(input mdu_op_e op);
      return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
   endfunction

   // rs2 is treated as two's complement.
   function automatic logic op_b_signed(input mdu_op_e op);
      return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
   endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational radix-2 iteration shared by multiply and divide.
//   i_is_div  1 = restoring divide step, 0 = shift-add multiply step
//   i_acc     2*XLEN working register
//               multiply: {partial product high, multiplier / product low}
//               divide:   {partial remainder, dividend / quotient}
//   i_opnd    multiplicand (multiply) or divisor (divide) magnitude
//   o_acc     working register after this iteration
module mdu_step
   import mdu_pkg::*;
#(
   parameter int XLEN = mdu_pkg::XLEN
) (
   input  logic                i_is_div,
   input  logic [2*XLEN-1:0]   i_acc,
   input  logic [XLEN-1:0]     i_opnd,
   output logic [2*XLEN-1:0]   o_acc
);

   logic [XLEN:0]   w_sum;
   logic [XLEN:0]   w_shrem;
   logic [XLEN-1:0] w_diff;
   logic [XLEN-1:0] w_newrem;
   logic            w_ge;

   always_comb begin
      // Multiply: add multiplicand into the high half when the current
      // multiplier bit (LSB) is set; the carry lands in bit XLEN and is
      // shifted back into the register below.
      w_sum = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_opnd & {XLEN{i_acc[0]}}};

      // Divide: shifted remainder needs XLEN+1 bits because the old
      // remainder can be as large as divisor-1.
      w_shrem  = i_acc[2*XLEN-1:XLEN-1];
      w_ge     = (w_shrem >= {1'b0, i_opnd});
      // Only used when w_ge, where the true difference fits in XLEN bits.
      w_diff   = w_shrem[XLEN-1:0] - i_opnd;
      w_newrem = w_ge ? w_diff : w_shrem[XLEN-1:0];

      if (i_is_div)
         o_acc = {w_newrem, i_acc[XLEN-2:0], w_ge};
      else
         o_acc = {w_sum, i_acc[XLEN-1:1]};
   end

endmodule

// File: rtl/mdu.sv
// mdu: iterative RISC-V M-extension multiply/divide unit.
//   clk, rst      clock and asynchronous active-high reset
//   req_valid/req_ready/req_op/req_a/req_b   request handshake and operands
//   kill          abort the operation in flight (pipeline flush)
//   resp_valid/resp_ready/resp_result        response handshake and result
//   busy          an operation has been accepted and not yet consumed
// Normal operations take XLEN iteration cycles; divide by zero and signed
// overflow are resolved at accept and answer one cycle later.
module mdu
   import mdu_pkg::*;
#(
   parameter int XLEN = mdu_pkg::XLEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [XLEN-1:0]  req_a,
   input  logic [XLEN-1:0]  req_b,
   input  logic             kill,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [XLEN-1:0]  resp_result,
   output logic             busy
);

   localparam int CW = $clog2(XLEN);

   mdu_state_e          r_state;
   mdu_op_e             r_op;
   logic [2*XLEN-1:0]   r_acc;
   logic [XLEN-1:0]     r_opnd;
   logic                r_neg_res;
   logic                r_neg_rem;
   logic [CW-1:0]       r_cnt;
   logic                r_resp_valid;
   logic [XLEN-1:0]     r_resp_result;

   mdu_op_e             w_op;
   logic                w_accept;
   logic                w_is_div;
   logic                w_a_neg;
   logic                w_b_neg;
   logic [XLEN-1:0]     w_mag_a;
   logic [XLEN-1:0]     w_mag_b;
   logic                w_div_zero;
   logic                w_div_ovf;
   logic [XLEN-1:0]     w_special;
   logic [2*XLEN-1:0]   w_step_acc;
   logic [2*XLEN-1:0]   w_prod;
   logic [XLEN-1:0]     w_quot;
   logic [XLEN-1:0]     w_rem;
   logic [XLEN-1:0]     w_result;

   // Ready only while idle, never during a flush, and not while reset is held.
   assign req_ready   = (r_state == MDU_IDLE) & ~kill & ~rst;
   assign w_accept    = req_valid & req_ready;
   assign resp_valid  = r_resp_valid;
   assign resp_result = r_resp_result;
   assign busy        = (r_state != MDU_IDLE);

   // ---------------------------------------------------------------
   // Request decode: operand magnitudes, sign flags, special cases
   // ---------------------------------------------------------------
   always_comb begin
      w_op       = mdu_op_e'(req_op);
      w_is_div   = op_is_div(w_op);
      w_a_neg    = op_a_signed(w_op) & req_a[XLEN-1];
      w_b_neg    = op_b_signed(w_op) & req_b[XLEN-1];
      w_mag_a    = w_a_neg ? (~req_a + 1'b1) : req_a;
      w_mag_b    = w_b_neg ? (~req_b + 1'b1) : req_b;
      w_div_zero = w_is_div & (req_b == '0);
      w_div_ovf  = ((w_op == MDU_DIV) || (w_op == MDU_REM)) &
                   (req_a == {1'b1, {(XLEN-1){1'b0}}}) & (req_b == '1);
      // Divide by zero: quotient all ones, remainder = dividend.
      // Overflow: quotient = dividend, remainder = 0.
      if (w_div_zero)
         w_special = op_is_rem(w_op) ? req_a : '1;
      else
         w_special = op_is_rem(w_op) ? '0 : req_a;
   end

   mdu_step #(.XLEN(XLEN)) u_step (
      .i_is_div (op_is_div(r_op)),
      .i_acc    (r_acc),
      .i_opnd   (r_opnd),
      .o_acc    (w_step_acc)
   );

   // ---------------------------------------------------------------
   // Sign fix-up and result selection, evaluated on the final step's
   // output so the registered result is ready when DONE is entered.
   // ---------------------------------------------------------------
   always_comb begin
      w_prod   = r_neg_res ? (~w_step_acc + 1'b1) : w_step_acc;
      w_quot   = r_neg_res ? (~w_step_acc[XLEN-1:0] + 1'b1) : w_step_acc[XLEN-1:0];
      w_rem    = r_neg_rem ? (~w_step_acc[2*XLEN-1:XLEN] + 1'b1) : w_step_acc[2*XLEN-1:XLEN];
      w_result = '0;
      case (r_op)
         MDU_MUL:                         w_result = w_prod[XLEN-1:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU: w_result = w_prod[2*XLEN-1:XLEN];
         MDU_DIV, MDU_DIVU:               w_result = w_quot;
         MDU_REM, MDU_REMU:               w_result = w_rem;
         default:                         w_result = '0;
      endcase
   end

   // ---------------------------------------------------------------
   // Control FSM with registered response
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= MDU_IDLE;
         r_op          <= MDU_MUL;
         r_acc         <= '0;
         r_opnd        <= '0;
         r_neg_res     <= 1'b0;
         r_neg_rem     <= 1'b0;
         r_cnt         <= '0;
         r_resp_valid  <= 1'b0;
         r_resp_result <= '0;
      end else begin
         case (r_state)
            MDU_IDLE: begin
               if (w_accept) begin
                  r_op      <= w_op;
                  r_neg_res <= w_a_neg ^ w_b_neg;
                  r_neg_rem <= w_a_neg;
                  r_cnt     <= '0;
                  if (w_div_zero || w_div_ovf) begin
                     r_resp_result <= w_special;
                     r_resp_valid  <= 1'b1;
                     r_state       <= MDU_DONE;
                  end else begin
                     // Multiply iterates over the multiplier (b) in the low
                     // half; divide shifts the dividend (a) out of the low half.
                     r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                     r_opnd  <= w_is_div ? w_mag_b : w_mag_a;
                     r_state <= MDU_CALC;
                  end
               end
            end

            MDU_CALC: begin
               if (kill) begin
                  r_state <= MDU_IDLE;
               end else begin
                  r_acc <= w_step_acc;
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == CW'(XLEN-1)) begin
                     r_resp_result <= w_result;
                     r_resp_valid  <= 1'b1;
                     r_state       <= MDU_DONE;
                  end
               end
            end

            MDU_DONE: begin
               // kill takes priority over a coincident resp_ready.
               if (kill) begin
                  r_resp_valid  <= 1'b0;
                  r_resp_result <= '0;
                  r_state       <= MDU_IDLE;
               end else if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_state      <= MDU_IDLE;
               end
            end

            default: begin
               r_resp_valid <= 1'b0;
               r_state      <= MDU_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed scoreboard testbench for mdu.
// The driver pushes the hand-computed result and latency of each accepted
// request into a queue; an independent monitor compares whatever the DUT
// presents on the response port against the head of that queue.
module tb_mdu;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        kill;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_result;
   logic        busy;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          t_acc;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   mdu #(.XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_a       (req_a),
      .req_b       (req_b),
      .kill        (kill),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic prev_v;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v = 1'b0;
         end else begin
            if (resp_valid) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_resp: got result %h, expected no response", resp_result);
               end else begin
                  if (!prev_v)
                     check({sb[0].name, "_latency"}, 32'(cyc - sb[0].t_acc), 32'(sb[0].lat));
                  check({sb[0].name, "_result"}, resp_result, sb[0].res);
                  if (resp_ready) begin
                     $display("resp %-8s result=%h at cycle %0d", sb[0].name, resp_result, cyc);
                     void'(sb.pop_front());
                  end
               end
            end
            prev_v = resp_valid & ~resp_ready;
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic start(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input int lat,
                        input bit push, output int t, output bit ok);
      exp_t e;
      ok = 1'b0;
      t  = 0;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1'b1;
            t  = cyc;
            if (push) begin
               e.res   = res;
               e.lat   = lat;
               e.t_acc = t;
               e.name  = nm;
               sb.push_back(e);
            end
         end
      end
      @(posedge clk); #1;
      // Scramble the request inputs: the unit must have captured them.
      req_valid = 1'b0;
      req_op    = 3'd3;
      req_a     = ~a;
      req_b     = ~b;
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_accept: got no req_ready, expected accept within 20 cycles", nm);
      end
   endtask

   task automatic wait_drain(input string nm);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(posedge clk); #2;
         if (sb.size() == 0) done = 1'b1;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: got no response, expected one within 100 cycles", nm);
         sb.delete();
      end
   endtask

   task automatic issue(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input int lat);
      int t;
      bit ok;
      start(nm, op, a, b, res, lat, 1'b1, t, ok);
      if (!ok) return;
      @(negedge clk);
      check({nm, "_busy_t1"}, 32'(busy), 32'd1);
      wait_drain(nm);
      @(negedge clk);
      check({nm, "_busy_after"}, 32'(busy), 32'd0);
      check({nm, "_ready_after"}, 32'(req_ready), 32'd1);
   endtask

   task automatic watch_quiet(input string nm);
      int highs;
      highs = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (resp_valid) highs++;
      end
      check({nm, "_no_resp"}, 32'(highs), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int  t;
      bit  ok;
      bit  seen;

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_op     = 3'd0;
      req_a      = '0;
      req_b      = '0;
      kill       = 1'b0;
      resp_ready = 1'b1;

      @(negedge clk);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_result", resp_result, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);

      // Multiply family
      issue("MUL",     MDU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
      issue("MULH",    MDU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
      issue("MULHU",   MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      issue("MULHSU",  MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
      issue("MULH_n5", MDU_MULH,   32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 33);
      issue("MUL_zero",MDU_MUL,    32'd0,        32'h00012345, 32'd0,        33);

      // Divide family
      issue("DIV",     MDU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      issue("REM",     MDU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      issue("DIVU",    MDU_DIVU,   32'd100,      32'd7,        32'd14,       33);
      issue("REMU",    MDU_REMU,   32'd100,      32'd7,        32'd2,        33);
      issue("DIVU_big",MDU_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        33);

      // Special cases: one-cycle answers
      issue("DIV_z",   MDU_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
      issue("REM_z",   MDU_REM,    32'd5,        32'd0,        32'd5,        1);
      issue("DIVU_z",  MDU_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
      issue("REMU_z",  MDU_REMU,   32'd9,        32'd0,        32'd9,        1);
      issue("DIV_ovf", MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      issue("REM_ovf", MDU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

      // Backpressure: hold the response, stray requests must be ignored
      resp_ready = 1'b0;
      start("BP_DIVU", MDU_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b1, t, ok);
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      check("bp_valid_seen", 32'(seen), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         req_valid = 1'b1;
         req_op    = MDU_MUL;
         req_a     = 32'd3;
         req_b     = 32'd4;
         @(negedge clk);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         check("bp_busy", 32'(busy), 32'd1);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      req_valid  = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_req_ready_after", 32'(req_ready), 32'd1);
      check("bp_busy_after", 32'(busy), 32'd0);
      check("bp_valid_after", 32'(resp_valid), 32'd0);

      // kill while idle blocks acceptance
      @(posedge clk); #1;
      kill      = 1'b1;
      req_valid = 1'b1;
      req_op    = MDU_DIVU;
      req_a     = 32'd50;
      req_b     = 32'd5;
      @(negedge clk);
      check("kill_idle_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      kill      = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      check("kill_idle_busy", 32'(busy), 32'd0);

      // kill at T+10 of a DIVU
      start("KILL_DIVU", MDU_DIVU, 32'd100, 32'd7, 32'd0, 0, 1'b0, t, ok);
      repeat (9) @(posedge clk);
      #1;
      check("kill_cycle", 32'(cyc - t), 32'd10);
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      @(negedge clk);
      check("kill_busy", 32'(busy), 32'd0);
      check("kill_req_ready", 32'(req_ready), 32'd1);
      watch_quiet("kill");

      // rst pulse at T+5 of a MUL
      start("RST_MUL", MDU_MUL, 32'd6, 32'd7, 32'd0, 0, 1'b0, t, ok);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_result", resp_result, 32'd0);
      check("rstmid_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      watch_quiet("rstmid");
      check("rstmid_ready_after", 32'(req_ready), 32'd1);

      // A normal operation still works after the flush and reset.
      issue("REMU_end", MDU_REMU, 32'hFFFFFFFF, 32'd10, 32'd5, 33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected completion within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
